instruction_cache: RTL and testbench

Direct-mapped, read-only instruction cache between the fetch stage and the 128-bit block instruction memory. A fetch that hits returns a 32-bit instruction in the same cycle. A fetch that misses stalls the fetch stage, requests the 16-byte block, waits out the memory's fixed latency, fills the line and then replays the lookup. This block is the requester that drives the memory's block address and captures its 128-bit output.

---
 rtl/instruction_cache_if.sv | 23 ++
 rtl/instruction_cache.sv | 127 ++++++++++++
 tb/tb_instruction_cache.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled for port connection.
// The cache takes the slave view; the fetch stage / memory environment takes the master view.
interface instruction_cache_if;
  logic [31:0]  pcAddress;
  logic         flush;
  logic [31:0]  instruction;
  logic         instructionReady;
  logic         stall;
  logic [31:0]  memAddress;
  logic [127:0] memData;
  logic [15:0]  hitCount;
  logic [15:0]  missCount;

  modport slave (
    input  pcAddress, flush, memData,
    output instruction, instructionReady, stall, memAddress, hitCount, missCount
  );

  modport master (
    output pcAddress, flush, memData,
    input  instruction, instructionReady, stall, memAddress, hitCount, missCount
  );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: hits return in the same cycle, misses cost 2+MEM_LATENCY cycles.
// Memory never pushes back; the fetch stage is held off with stall while a miss is in flight.
module instruction_cache #(
  parameter int LINES       = 16,
  parameter int MEM_LATENCY = 6
) (
  input logic clock,
  input logic reset,
  instruction_cache_if.slave bus
);
  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = 28 - IDXW;
  localparam int WCW  = $clog2(MEM_LATENCY + 1);
  localparam logic [WCW-1:0] LAST_WAIT = WCW'(MEM_LATENCY);

  typedef enum logic [1:0] {LOOKUP, PRIME, WAIT} state_t;
  state_t state, stateNext;

  logic [LINES-1:0] valid;
  logic [TAGW-1:0]  tagArray  [LINES];
  logic [127:0]     dataArray [LINES];

  logic [27:0]     missBlock;
  logic [31:0]     memAddress;
  logic [WCW-1:0]  waitCount;
  logic            flushPending;
  logic [15:0]     hitCount;
  logic [15:0]     missCount;

  logic [IDXW-1:0] pcIndex;
  logic [TAGW-1:0] pcTag;
  logic [IDXW-1:0] fillIndex;
  logic            hit;
  logic            fillNow;
  logic [127:0]    lineData;
  logic [31:0]     wordSel;
  logic [1:0]      unusedPcBits;

  assign pcIndex      = bus.pcAddress[4 +: IDXW];
  assign pcTag        = bus.pcAddress[31 -: TAGW];
  assign unusedPcBits = bus.pcAddress[1:0];
  assign fillIndex    = missBlock[IDXW-1:0];

  assign hit      = (state == LOOKUP) && valid[pcIndex] && (tagArray[pcIndex] == pcTag);
  assign fillNow  = (state == WAIT) && (waitCount == LAST_WAIT);
  assign lineData = dataArray[pcIndex];

  // Byte 0 of the block sits in the top bits, so word 0 is the most significant word.
  always_comb begin
    wordSel = 32'd0;
    case (bus.pcAddress[3:2])
      2'd0: wordSel = lineData[127:96];
      2'd1: wordSel = lineData[95:64];
      2'd2: wordSel = lineData[63:32];
      2'd3: wordSel = lineData[31:0];
      default: wordSel = 32'd0;
    endcase
  end

  always_comb begin
    stateNext = state;
    case (state)
      LOOKUP:  if (!hit) stateNext = PRIME;
      PRIME:   stateNext = WAIT;
      WAIT:    if (fillNow) stateNext = LOOKUP;
      default: stateNext = LOOKUP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= LOOKUP;
      valid        <= '0;
      missBlock    <= '0;
      memAddress   <= '0;
      waitCount    <= '0;
      flushPending <= 1'b0;
      hitCount     <= '0;
      missCount    <= '0;
    end else begin
      state <= stateNext;
      if (hit && hitCount != 16'hFFFF) hitCount <= hitCount + 16'd1;
      case (state)
        LOOKUP: begin
          if (bus.flush) valid <= '0;
          if (!hit) begin
            missBlock  <= bus.pcAddress[31:4];
            // Offset the first address so the memory always sees an address change.
            memAddress <= {bus.pcAddress[31:5], ~bus.pcAddress[4], 4'b0000};
            if (missCount != 16'hFFFF) missCount <= missCount + 16'd1;
          end
        end
        PRIME: begin
          memAddress <= {missBlock, 4'b0000};
          waitCount  <= WCW'(1);
          if (bus.flush) flushPending <= 1'b1;
        end
        WAIT: begin
          if (fillNow) begin
            waitCount    <= '0;
            flushPending <= 1'b0;
            if (bus.flush || flushPending) valid <= '0;
            else valid[fillIndex] <= 1'b1;
          end else begin
            waitCount <= waitCount + 1'b1;
            if (bus.flush) flushPending <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && fillNow) begin
      dataArray[fillIndex] <= bus.memData;
      tagArray[fillIndex]  <= missBlock[27 -: TAGW];
    end
  end

  assign bus.instruction      = hit ? wordSel : 32'd0;
  assign bus.instructionReady = hit;
  assign bus.stall            = ~hit;
  assign bus.memAddress       = memAddress;
  assign bus.hitCount         = hitCount;
  assign bus.missCount        = missCount;
endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: directed plan then random fetches against a line-level cache model
// and a 1-KB memory that only presents data once its address has been stable long enough.
module tb_instruction_cache;
  localparam int LINES       = 16;
  localparam int MEM_LATENCY = 6;

  logic clock = 1'b0;
  logic reset;

  instruction_cache_if bus ();

  instruction_cache #(.LINES(LINES), .MEM_LATENCY(MEM_LATENCY)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Memory: the address age restarts whenever memAddress changes; data is garbage until it has aged.
  logic [7:0]  mem [0:1023];
  logic [31:0] lastAddr = 32'd0;
  int          age = 0;

  always @(negedge clock) begin
    if (bus.memAddress !== lastAddr) begin
      lastAddr = bus.memAddress;
      age = 0;
    end else if (age < 1000) begin
      age++;
    end
    if (age >= MEM_LATENCY - 1) begin
      for (int b = 0; b < 16; b++)
        bus.memData[127-8*b -: 8] = mem[{lastAddr[9:4], 4'b0000} + b];
    end else begin
      bus.memData = {4{32'hDEADBEEF}};
    end
  end

  // Reference model: which blocks are resident, plus counters.
  logic        mValid [LINES];
  logic [31:0] mTag   [LINES];
  int hits   = 0;
  int misses = 0;
  int checks = 0;
  int passed = 0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    int p;
    p = int'({a[9:2], 2'b00});
    return {mem[p], mem[p+1], mem[p+2], mem[p+3]};
  endfunction

  task automatic clearModel();
    for (int i = 0; i < LINES; i++) mValid[i] = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Called just after a falling edge. flushAt: cycle of the first attempt (0 = lookup cycle) to pulse flush, -1 none.
  task automatic fetch(input logic [31:0] pc, input int flushAt);
    int          idx;
    logic [31:0] tg;
    logic [31:0] blk;
    logic        flushed;
    int          fAt;
    fAt = flushAt;
    idx = int'((pc >> 4) % LINES);
    tg  = pc / (16 * LINES);
    blk = pc & 32'hFFFF_FFF0;
    bus.pcAddress = pc;
    for (int iter = 0; iter < 3; iter++) begin
      bus.flush = (fAt == 0);
      #1;
      if (mValid[idx] && mTag[idx] == tg) begin
        check("hit_ready", 32'(bus.instructionReady), 32'd1);
        check("hit_stall", 32'(bus.stall), 32'd0);
        check("hit_instr", bus.instruction, memWord(pc));
        if (hits < 65535) hits++;
        if (bus.flush) clearModel();
        @(negedge clock);
        bus.flush = 1'b0;
        check("hitCount", 32'(bus.hitCount), 32'(hits));
        return;
      end
      check("miss_stall", 32'(bus.stall), 32'd1);
      check("miss_instr", bus.instruction, 32'd0);
      if (misses < 65535) misses++;
      if (bus.flush) clearModel();
      flushed = 1'b0;
      for (int c = 1; c <= MEM_LATENCY + 1; c++) begin
        @(negedge clock);
        bus.flush = (fAt == c);
        #1;
        if (bus.flush) flushed = 1'b1;
        check("wait_stall", 32'(bus.stall), 32'd1);
        check("memAddress", bus.memAddress, (c == 1) ? (blk ^ 32'h10) : blk);
      end
      @(negedge clock);
      bus.flush = 1'b0;
      if (flushed) clearModel();
      else begin
        mValid[idx] = 1'b1;
        mTag[idx]   = tg;
      end
      check("missCount", 32'(bus.missCount), 32'(misses));
      fAt = -1;
    end
    checks++;
    $error("FAIL fetch_bound: pc 0x%08h never became ready", pc);
  endtask

  initial begin
    logic [159:0] head;
    head = 160'h00430800_00A62001_01093802_016C5003_01CF6804;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 20; i++) mem[i] = head[159-8*i -: 8];
    mem[12'h030] = 8'h18; mem[12'h031] = 8'h00; mem[12'h032] = 8'hFF; mem[12'h033] = 8'hF3;
    mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
    clearModel();

    reset = 1'b1;
    bus.pcAddress = 32'd0;
    bus.flush = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1;
    check("rst_instr", bus.instruction, 32'd0);
    check("rst_ready", 32'(bus.instructionReady), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd1);
    check("rst_memAddress", bus.memAddress, 32'd0);
    check("rst_hitCount", 32'(bus.hitCount), 32'd0);
    check("rst_missCount", 32'(bus.missCount), 32'd0);
    reset = 1'b0;

    // Cold miss, same-line hits, held pc
    fetch(32'h0, -1);
    fetch(32'h4, -1);
    fetch(32'hC, -1);
    fetch(32'hC, -1);
    fetch(32'hC, -1);
    // Second block and a neighbouring block
    fetch(32'h30, -1);
    fetch(32'h10, -1);
    // Conflict on line 0
    fetch(32'h100, -1);
    fetch(32'h0, -1);
    // Flush in LOOKUP, then a line that was resident misses
    fetch(32'h0, 0);
    fetch(32'h4, -1);
    // Flush during WAIT: the freshly filled line is dropped and refetched
    fetch(32'h100, -1);
    fetch(32'h0, 4);
    // Miss together with flush in the lookup cycle
    fetch(32'h40, 0);

    // Reset on the third WAIT cycle aborts the miss
    fetch(32'h100, -1);
    bus.pcAddress = 32'h0;
    #1;
    check("abort_miss_stall", 32'(bus.stall), 32'd1);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_memAddress", bus.memAddress, 32'd0);
    check("abort_hitCount", 32'(bus.hitCount), 32'd0);
    check("abort_missCount", 32'(bus.missCount), 32'd0);
    check("abort_stall", 32'(bus.stall), 32'd1);
    clearModel();
    hits = 0;
    misses = 0;
    fetch(32'h0, -1);

    // Random fetches across the 1-KB space (cache covers 256 bytes)
    for (int n = 0; n < 60; n++) begin
      logic [31:0] pc;
      int f;
      pc = 32'($urandom_range(0, 255)) << 2;
      f  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      fetch(pc, f);
    end

    // Hit counter saturation
    fetch(32'h30, -1);
    repeat (65540) @(negedge clock);
    hits = (hits + 65540 > 65535) ? 65535 : hits + 65540;
    #1;
    check("hitCount_sat", 32'(bus.hitCount), 32'(hits));
    check("sat_instr", bus.instruction, memWord(32'h30));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1, "timeout");
  end
endmodule
